coin_fx: RTL and testbench

- Frame-rate consumer of the coin-collection interface. Inputs: per-coin active flags `coin_collides` (1 = uncollected) and per-coin screen-relative positions, as produced by the coin collision block.
- Detects each collection, runs a pop-up animation per collected coin and drives a shared spin animation for idle coins.
- Keeps a 2-digit BCD coin counter with a 1-up pulse at 100.
- Provides a combinational per-pixel hit/sprite-address lookup for the VGA colour mapper.

---
 rtl/coin_pkg.sv | 27 ++
 rtl/coin_bcd_counter.sv | 41 ++++
 rtl/coin_fx.sv | 144 ++++++++++++++
 tb/tb_coin_fx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types, sizes and the sprite-box test used by the coin effects block.
package coin_pkg;
    localparam int NUM_COINS  = 8;
    localparam int POP_FRAMES = 16;
    localparam int POP_RISE   = 4;
    localparam int SPIN_DIV   = 8;
    localparam int COIN_HALF  = 16;
    localparam int CNT_W      = $clog2(NUM_COINS + 1);

    localparam logic [1:0] GAME_PLAYING = 2'b01;

    typedef logic [17:0] coin_coord_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Box span [c-HALF, c+HALF); low edge clips at 0, a centre with bit 17 set is off-screen.
    function automatic logic in_span(input coin_coord_t c, input coin_coord_t d);
        coin_coord_t lo;
        coin_coord_t hi;
        lo = (c < coin_coord_t'(COIN_HALF)) ? '0 : c - coin_coord_t'(COIN_HALF);
        hi = c + coin_coord_t'(COIN_HALF);
        return !c[17] && (d >= lo) && (d < hi);
    endfunction
endpackage

// File: rtl/coin_bcd_counter.sv
// Two-digit BCD coin counter: adds 0..NUM_COINS per frame, wraps mod 100, pulses one_up on wrap.
module coin_bcd_counter
    import coin_pkg::*;
(
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] n,
    output bcd2_t            coins_bcd,
    output logic             one_up
);
    bcd2_t count_reg, count_next;
    logic  one_up_reg, one_up_next;
    logic [4:0] ones_sum, ones_adj;
    logic [4:0] tens_sum;
    logic       ones_carry;

    // n never exceeds 9, so the ones digit carries at most once.
    always_comb begin
        ones_sum   = {1'b0, count_reg.ones} + 5'(n);
        ones_carry = (ones_sum >= 5'd10);
        ones_adj   = ones_carry ? ones_sum - 5'd10 : ones_sum;
        tens_sum   = {1'b0, count_reg.tens} + {4'd0, ones_carry};
        count_next.ones = ones_adj[3:0];
        count_next.tens = (tens_sum >= 5'd10) ? 4'd0 : tens_sum[3:0];
        one_up_next     = (tens_sum >= 5'd10);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset || clear) begin
            count_reg  <= '0;
            one_up_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            one_up_reg <= one_up_next;
        end
    end

    assign coins_bcd = count_reg;
    assign one_up    = one_up_reg;
endmodule

// File: rtl/coin_fx.sv
// Coin collection effects: edge detect, per-slot pop-up, idle spin, BCD counter, pixel lookup.
module coin_fx
    import coin_pkg::*;
(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [1:0]  state,
    input  logic [NUM_COINS-1:0] coin_collides,
    input  coin_coord_t coin_pos_x_rel [NUM_COINS],
    input  coin_coord_t coin_pos_y_rel [NUM_COINS],
    input  coin_coord_t DrawX,
    input  coin_coord_t DrawY,
    output logic [1:0]  spin_frame,
    output logic [NUM_COINS-1:0] pop_active,
    output coin_coord_t pop_y [NUM_COINS],
    output logic [7:0]  coins_bcd,
    output logic        one_up,
    output logic        coin_pixel_on,
    output logic [4:0]  coin_sprite_x,
    output logic [4:0]  coin_sprite_y,
    output logic [1:0]  coin_sprite_frame
);
    localparam int SPIN_W = $clog2(SPIN_DIV);
    localparam int POP_W  = $clog2(POP_FRAMES);

    logic clear;
    logic [NUM_COINS-1:0] prev_collides_reg, collect_evt;
    logic [SPIN_W-1:0] spin_div_reg;
    logic [1:0]        spin_frame_reg;
    logic [NUM_COINS-1:0] pop_active_reg;
    logic [POP_W-1:0]  pop_count_reg [NUM_COINS];
    coin_coord_t       pop_base_y_reg [NUM_COINS];
    logic [CNT_W-1:0]  collect_n;
    bcd2_t             bcd_w;

    logic [NUM_COINS-1:0] idle_hit, pop_hit;
    coin_coord_t off_x [NUM_COINS];
    coin_coord_t off_iy [NUM_COINS];
    coin_coord_t off_py [NUM_COINS];

    assign clear       = Reset || (state != GAME_PLAYING);
    assign collect_evt = prev_collides_reg & ~coin_collides;

    always_ff @(posedge frame_clk) begin
        if (clear) begin
            prev_collides_reg <= '1;
            spin_div_reg      <= '0;
            spin_frame_reg    <= '0;
        end else begin
            prev_collides_reg <= coin_collides;
            if (spin_div_reg == SPIN_W'(SPIN_DIV - 1)) begin
                spin_div_reg   <= '0;
                spin_frame_reg <= spin_frame_reg + 2'd1;
            end else begin
                spin_div_reg <= spin_div_reg + 1'b1;
            end
        end
    end

    always_comb begin
        collect_n = '0;
        for (int i = 0; i < NUM_COINS; i++)
            collect_n = collect_n + CNT_W'(collect_evt[i]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_slot
            coin_coord_t rise;

            // A new collection on a running slot restarts its animation.
            always_ff @(posedge frame_clk) begin
                if (clear) begin
                    pop_active_reg[gi] <= 1'b0;
                    pop_count_reg[gi]  <= '0;
                    pop_base_y_reg[gi] <= '0;
                end else if (collect_evt[gi]) begin
                    pop_active_reg[gi] <= 1'b1;
                    pop_count_reg[gi]  <= '0;
                    pop_base_y_reg[gi] <= coin_pos_y_rel[gi];
                end else if (pop_active_reg[gi]) begin
                    if (pop_count_reg[gi] == POP_W'(POP_FRAMES - 1)) begin
                        pop_active_reg[gi] <= 1'b0;
                        pop_count_reg[gi]  <= '0;
                    end else begin
                        pop_count_reg[gi] <= pop_count_reg[gi] + 1'b1;
                    end
                end
            end

            assign rise      = coin_coord_t'(pop_count_reg[gi]) * coin_coord_t'(POP_RISE);
            assign pop_y[gi] = (pop_base_y_reg[gi] < rise) ? '0 : pop_base_y_reg[gi] - rise;

            assign idle_hit[gi] = coin_collides[gi]
                                  && in_span(coin_pos_x_rel[gi], DrawX)
                                  && in_span(coin_pos_y_rel[gi], DrawY);
            assign pop_hit[gi]  = pop_active_reg[gi]
                                  && in_span(coin_pos_x_rel[gi], DrawX)
                                  && in_span(pop_y[gi], DrawY);

            // Texel offset uses modular arithmetic so clipped boxes still address correctly.
            assign off_x[gi]  = DrawX - coin_pos_x_rel[gi] + coin_coord_t'(COIN_HALF);
            assign off_iy[gi] = DrawY - coin_pos_y_rel[gi] + coin_coord_t'(COIN_HALF);
            assign off_py[gi] = DrawY - pop_y[gi] + coin_coord_t'(COIN_HALF);
        end
    endgenerate

    // Later assignments win: pops first, then idle coins, both scanned high to low index.
    always_comb begin
        coin_pixel_on     = 1'b0;
        coin_sprite_x     = '0;
        coin_sprite_y     = '0;
        coin_sprite_frame = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (pop_hit[i]) begin
                coin_pixel_on     = 1'b1;
                coin_sprite_x     = off_x[i][4:0];
                coin_sprite_y     = off_py[i][4:0];
                coin_sprite_frame = pop_count_reg[i][1:0];
            end
        end
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (idle_hit[i]) begin
                coin_pixel_on     = 1'b1;
                coin_sprite_x     = off_x[i][4:0];
                coin_sprite_y     = off_iy[i][4:0];
                coin_sprite_frame = spin_frame_reg;
            end
        end
    end

    coin_bcd_counter u_counter (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (clear),
        .n         (collect_n),
        .coins_bcd (bcd_w),
        .one_up    (one_up)
    );

    assign coins_bcd  = bcd_w;
    assign spin_frame = spin_frame_reg;
    assign pop_active = pop_active_reg;
endmodule

// File: tb/tb_coin_fx.sv
// Self-checking bench for coin_fx: frame-level behavioural model plus directed literal checks.
module tb_coin_fx;
    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [1:0]  state;
    logic [7:0]  coin_collides;
    logic [17:0] x_rel [8];
    logic [17:0] y_rel [8];
    logic [17:0] DrawX, DrawY;
    logic [1:0]  spin_frame;
    logic [7:0]  pop_active;
    logic [17:0] pop_y [8];
    logic [7:0]  coins_bcd;
    logic        one_up;
    logic        coin_pixel_on;
    logic [4:0]  coin_sprite_x, coin_sprite_y;
    logic [1:0]  coin_sprite_frame;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pop age (-1 = idle), coin total as an integer, frames spent playing.
    int m_age [8];
    int m_base [8];
    int m_total;
    int m_frames;
    bit m_one_up;
    bit m_prev [8];

    coin_fx dut (
        .frame_clk         (frame_clk),
        .Reset             (Reset),
        .state             (state),
        .coin_collides     (coin_collides),
        .coin_pos_x_rel    (x_rel),
        .coin_pos_y_rel    (y_rel),
        .DrawX             (DrawX),
        .DrawY             (DrawY),
        .spin_frame        (spin_frame),
        .pop_active        (pop_active),
        .pop_y             (pop_y),
        .coins_bcd         (coins_bcd),
        .one_up            (one_up),
        .coin_pixel_on     (coin_pixel_on),
        .coin_sprite_x     (coin_sprite_x),
        .coin_sprite_y     (coin_sprite_y),
        .coin_sprite_frame (coin_sprite_frame)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_popy(input int i);
        int v;
        v = m_base[i] - 4 * m_age[i];
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int m_bcd();
        return (m_total / 10) * 16 + (m_total % 10);
    endfunction

    function automatic int m_spin();
        return (m_frames / 8) % 4;
    endfunction

    function automatic bit m_hit(input int c, input int d);
        if (c >= 131072) return 1'b0;
        return (d >= c - 16) && (d < c + 16);
    endfunction

    always @(posedge frame_clk) begin
        int n;
        if (Reset || state != 2'b01) begin
            for (int i = 0; i < 8; i++) begin
                m_age[i]  = -1;
                m_base[i] = 0;
                m_prev[i] = 1'b1;
            end
            m_total  = 0;
            m_frames = 0;
            m_one_up = 1'b0;
        end else begin
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (m_prev[i] && !coin_collides[i]) begin
                    n++;
                    m_age[i]  = 0;
                    m_base[i] = int'(y_rel[i]);
                end else if (m_age[i] >= 0) begin
                    m_age[i] = (m_age[i] == 15) ? -1 : m_age[i] + 1;
                end
                m_prev[i] = coin_collides[i];
            end
            m_one_up = (m_total + n >= 100);
            m_total  = (m_total + n) % 100;
            m_frames++;
        end
    end

    // Compare every frame, 1 time unit after the edge.
    always begin
        int e_on, e_sx, e_sy, e_fr, dx, dy;
        @(posedge frame_clk);
        #1;
        chk("coins_bcd", int'(coins_bcd), m_bcd());
        chk("one_up", int'(one_up), int'(m_one_up));
        chk("spin_frame", int'(spin_frame), m_spin());
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pop_active[%0d]", i), int'(pop_active[i]), int'(m_age[i] >= 0));
            if (m_age[i] >= 0)
                chk($sformatf("pop_y[%0d]", i), int'(pop_y[i]), m_popy(i));
        end
        dx = int'(DrawX);
        dy = int'(DrawY);
        e_on = 0; e_sx = 0; e_sy = 0; e_fr = 0;
        for (int i = 0; i < 8 && e_on == 0; i++) begin
            if (coin_collides[i] && m_hit(int'(x_rel[i]), dx) && m_hit(int'(y_rel[i]), dy)) begin
                e_on = 1;
                e_sx = (dx - int'(x_rel[i]) + 16) & 31;
                e_sy = (dy - int'(y_rel[i]) + 16) & 31;
                e_fr = m_spin();
            end
        end
        for (int i = 0; i < 8 && e_on == 0; i++) begin
            if (m_age[i] >= 0 && m_hit(int'(x_rel[i]), dx) && m_hit(m_popy(i), dy)) begin
                e_on = 1;
                e_sx = (dx - int'(x_rel[i]) + 16) & 31;
                e_sy = (dy - m_popy(i) + 16) & 31;
                e_fr = m_age[i] % 4;
            end
        end
        chk("pixel_on", int'(coin_pixel_on), e_on);
        chk("sprite_x", int'(coin_sprite_x), e_sx);
        chk("sprite_y", int'(coin_sprite_y), e_sy);
        chk("sprite_frame", int'(coin_sprite_frame), e_fr);
    end

    task automatic step(input int k);
        for (int j = 0; j < k; j++) begin
            @(posedge frame_clk);
            #2;
        end
    endtask

    initial begin
        int active_frames;
        int waited;
        Reset = 1'b1;
        state = 2'b00;
        coin_collides = 8'hFF;
        DrawX = '0;
        DrawY = '0;
        x_rel[0] = 18'd100; x_rel[1] = 18'd400; x_rel[2] = 18'd160; x_rel[3] = 18'd220;
        x_rel[4] = 18'd280; x_rel[5] = 18'd520; x_rel[6] = 18'd580; x_rel[7] = 18'd640;
        for (int i = 0; i < 8; i++) y_rel[i] = 18'd240;
        step(3);
        Reset = 1'b0;
        state = 2'b01;
        step(2);
        $display("reset released: bcd=%02h one_up=%0d pop_active=%02h", coins_bcd, one_up, pop_active);
        chk("reset_bcd", int'(coins_bcd), 0);
        chk("reset_pop_active", int'(pop_active), 0);
        chk("reset_one_up", int'(one_up), 0);

        // Single collection on slot 2.
        step(8);
        coin_collides[2] = 1'b0;
        step(1);
        $display("collect slot2: bcd=%02h pop_y2=%0d", coins_bcd, pop_y[2]);
        chk("c2_bcd", int'(coins_bcd), 8'h01);
        chk("c2_pop_y_first", int'(pop_y[2]), 240);
        active_frames = 0;
        for (int f = 0; f < 20; f++) begin
            if (pop_active[2]) begin
                active_frames++;
                if (active_frames == 16) chk("c2_pop_y_last", int'(pop_y[2]), 180);
            end
            step(1);
        end
        $display("slot2 pop lasted %0d frames", active_frames);
        chk("c2_pop_frames", active_frames, 16);

        // Three simultaneous collections.
        coin_collides = coin_collides & ~8'b1010_0001;
        step(1);
        $display("collect 0,5,7: bcd=%02h pop_active=%02h", coins_bcd, pop_active);
        chk("c3_bcd", int'(coins_bcd), 8'h04);
        chk("c3_pops", int'(pop_active & 8'b1010_0001), 8'b1010_0001);

        // Pump the counter up to 98.
        for (int r = 0; r < 11; r++) begin
            coin_collides = 8'hFF; step(1);
            coin_collides = 8'h00; step(1);
        end
        coin_collides = 8'hFF; step(1);
        coin_collides = 8'hC0; step(1);
        $display("pumped: bcd=%02h", coins_bcd);
        chk("pump_bcd", int'(coins_bcd), 8'h98);
        coin_collides = 8'hFF; step(1);
        coin_collides = 8'hF8; step(1);
        $display("wrap: bcd=%02h one_up=%0d", coins_bcd, one_up);
        chk("wrap_bcd", int'(coins_bcd), 8'h01);
        chk("wrap_one_up", int'(one_up), 1);
        step(1);
        $display("after wrap: bcd=%02h one_up=%0d", coins_bcd, one_up);
        chk("wrap_one_up_clear", int'(one_up), 0);

        // Pixel lookup with all pops finished and spin_frame = 2.
        coin_collides = 8'hFF;
        step(20);
        waited = 0;
        while (m_spin() != 2 && waited < 40) begin
            step(1);
            waited++;
        end
        if (waited >= 40) chk("spin_wait_timeout", 1, 0);
        DrawX = 18'd384; DrawY = 18'd224;
        #1;
        $display("pixel (384,224): on=%0d sx=%0d sy=%0d fr=%0d", coin_pixel_on, coin_sprite_x, coin_sprite_y, coin_sprite_frame);
        chk("px_on", int'(coin_pixel_on), 1);
        chk("px_sx", int'(coin_sprite_x), 0);
        chk("px_sy", int'(coin_sprite_y), 0);
        chk("px_frame", int'(coin_sprite_frame), 2);
        DrawX = 18'd416;
        #1;
        $display("pixel (416,224): on=%0d", coin_pixel_on);
        chk("px_right_edge", int'(coin_pixel_on), 0);
        x_rel[1] = 18'h3FFF0; DrawX = 18'h3FFF0; DrawY = 18'd240;
        #1;
        $display("pixel offscreen coin: on=%0d", coin_pixel_on);
        chk("px_offscreen", int'(coin_pixel_on), 0);
        x_rel[1] = 18'd5; DrawX = 18'd0;
        #1;
        $display("pixel clipped coin: on=%0d sx=%0d sy=%0d", coin_pixel_on, coin_sprite_x, coin_sprite_y);
        chk("px_clip_on", int'(coin_pixel_on), 1);
        chk("px_clip_sx", int'(coin_sprite_x), 11);
        chk("px_clip_sy", int'(coin_sprite_y), 16);
        x_rel[1] = 18'd400; DrawX = '0; DrawY = '0;
        step(1);

        // Leave the playing state mid-pop.
        coin_collides = 8'hF0;
        step(2);
        $display("before state drop: bcd=%02h pop_active=%02h", coins_bcd, pop_active);
        chk("gate_bcd_before", int'(coins_bcd), 8'h05);
        state = 2'b00;
        coin_collides = 8'hFF;
        step(1);
        $display("state 00: bcd=%02h pop_active=%02h", coins_bcd, pop_active);
        chk("gate_bcd", int'(coins_bcd), 0);
        chk("gate_pops", int'(pop_active), 0);
        state = 2'b01;
        step(3);
        $display("back to play: bcd=%02h pop_active=%02h", coins_bcd, pop_active);
        chk("resume_bcd", int'(coins_bcd), 0);
        chk("resume_pops", int'(pop_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
